// File: rtl/div_unit.sv
// div_unit: multi-cycle signed divide / remainder unit.
//
// This unit sits beside the single-cycle ALU. It runs the R-type div
// (alu_control 4'b0100) and rem (alu_control 4'b0101) operations with
// unsigned restoring division on operand magnitudes, one quotient bit per
// clock, MSB first. A sign fix-up is applied to the result on the way into
// DONE. While busy is high the datapath stalls the PC and holds the
// register-file write.
//
// Optional build macro: DIV_FAST_SPECIAL_EN
//   defined   - divide-by-zero and overflow operands skip the iterations.
//               They leave CALC one edge after the accept, with the same
//               results as the full-length path.
//   undefined - every operation takes the full WIDTH+1 edge latency.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        request a new operation; sampled only in IDLE
//   alu_control  4'b0100 = div, 4'b0101 = rem; other codes are ignored
//   a            dividend (rs1), two's complement
//   b            divisor  (rs2), two's complement
//   busy         high in CALC and DONE
//   done         one-cycle pulse; result is valid in this cycle
//   result       quotient (div) or remainder (rem); holds until the next DONE
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [3:0] OP_DIV = 4'b0100;
  localparam logic [3:0] OP_REM = 4'b0101;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef DIV_FAST_SPECIAL_EN
  localparam bit FAST_EN = 1'b1;
`else
  localparam bit FAST_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q,    state_d;
  logic             is_rem_q,   is_rem_d;
  logic             sign_a_q,   sign_a_d;
  logic             neg_q,      neg_d;
  logic             div_zero_q, div_zero_d;
  logic             special_q,  special_d;
  logic             last_q,     last_d;
  logic [CW-1:0]    cnt_q,      cnt_d;
  logic [WIDTH-1:0] quo_q,      quo_d;     // |a| shifted out MSB first, quotient bits shifted in
  logic [WIDTH-1:0] rem_q,      rem_d;     // partial remainder (always < |b|)
  logic [WIDTH-1:0] dsr_q,      dsr_d;     // |b|
  logic [WIDTH-1:0] a_q,        a_d;       // original dividend, returned by rem-by-zero
  logic [WIDTH-1:0] result_q,   result_d;

  logic             accept;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] quo_fix, rem_fix, special_res, final_res;

  always_comb begin
    accept = (state_q == IDLE) && start &&
             ((alu_control == OP_DIV) || (alu_control == OP_REM));

    // For the most negative value the negation wraps back to 2^(WIDTH-1),
    // which is exactly the right unsigned magnitude.
    abs_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    abs_b = b[WIDTH-1] ? (~b + 1'b1) : b;

    // Shifted partial remainder is one bit wider than the divisor so the
    // trial subtraction's borrow shows up in the top bit.
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dsr_q};

    quo_fix = neg_q    ? (~quo_q + 1'b1) : quo_q;
    rem_fix = sign_a_q ? (~rem_q + 1'b1) : rem_q;

    if (div_zero_q)
      special_res = is_rem_q ? a_q : {WIDTH{1'b1}};
    else
      special_res = is_rem_q ? {WIDTH{1'b0}} : MIN_VAL;

    // Overflow is not overridden here: the magnitude arithmetic already
    // yields quotient 2^(WIDTH-1) and remainder 0.
    if (div_zero_q)
      final_res = special_res;
    else
      final_res = is_rem_q ? rem_fix : quo_fix;
  end

  always_comb begin
    state_d    = state_q;
    is_rem_d   = is_rem_q;
    sign_a_d   = sign_a_q;
    neg_d      = neg_q;
    div_zero_d = div_zero_q;
    special_d  = special_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dsr_d      = dsr_q;
    a_d        = a_q;
    result_d   = result_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = CALC;
          is_rem_d   = alu_control[0];
          sign_a_d   = a[WIDTH-1];
          neg_d      = a[WIDTH-1] ^ b[WIDTH-1];
          div_zero_d = (b == '0);
          special_d  = (b == '0) || ((a == MIN_VAL) && (b == {WIDTH{1'b1}}));
          last_d     = 1'b0;
          cnt_d      = CW'(WIDTH - 1);
          quo_d      = abs_a;
          rem_d      = '0;
          dsr_d      = abs_b;
          a_d        = a;
        end
      end

      CALC: begin
        if (FAST_EN && special_q) begin
          state_d  = DONE;
          result_d = special_res;
        end else if (last_q) begin
          // Extra cycle after the counter-0 iteration applies the sign fix.
          state_d  = DONE;
          result_d = final_res;
        end else begin
          if (trial[WIDTH]) begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end else begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end
          if (cnt_q == '0)
            last_d = 1'b1;
          else
            cnt_d = cnt_q - 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      is_rem_q   <= 1'b0;
      sign_a_q   <= 1'b0;
      neg_q      <= 1'b0;
      div_zero_q <= 1'b0;
      special_q  <= 1'b0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dsr_q      <= '0;
      a_q        <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      is_rem_q   <= is_rem_d;
      sign_a_q   <= sign_a_d;
      neg_q      <= neg_d;
      div_zero_q <= div_zero_d;
      special_q  <= special_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dsr_q      <= dsr_d;
      a_q        <= a_d;
      result_q   <= result_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed testbench for div_unit (WIDTH = 32).
module tb_div_unit;

  localparam int W = 32;
  localparam logic [3:0] OP_DIV = 4'b0100;
  localparam logic [3:0] OP_REM = 4'b0101;

`ifdef DIV_FAST_SPECIAL_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = W + 1;
`endif
  localparam int NORMAL_LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   alu_control = 4'b0000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int n_cmp  = 0;
  int n_fail = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .alu_control (alu_control),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result      (result)
  );

  always #5 clk = ~clk;

  // Counts edges until done is seen (#1 after each edge); -1 on timeout.
  task automatic wait_done(output int lat, output logic [W-1:0] res);
    lat = -1;
    res = '0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        res = result;
        break;
      end
    end
  endtask

  // Issues one operation, returns result and latency, then steps past DONE.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] aa,
                        input logic [W-1:0] bb,
                        output logic [W-1:0] res, output int lat);
    @(negedge clk);
    alu_control = op;
    a = aa;
    b = bb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Operands changing after the accept must not matter.
    a = $urandom;
    b = $urandom;
    alu_control = 4'b0000;
    wait_done(lat, res);
    $display("op=%b a=%h b=%h -> result=%h latency=%0d", op, aa, bb, res, lat);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #12;
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++;
    if (result !== '0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
    @(negedge clk);
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_basic_div;
    logic [W-1:0] res;
    int lat;
    run_op(OP_DIV, 32'd100, 32'd7, res, lat);
    n_cmp++;
    if (res !== 32'd14) begin n_fail++; $display("FAIL basic_div_result: got %h expected %h", res, 32'd14); end
    n_cmp++;
    if (lat !== NORMAL_LAT) begin n_fail++; $display("FAIL basic_div_latency: got %0d expected %0d", lat, NORMAL_LAT); end
    run_op(OP_REM, 32'd100, 32'd7, res, lat);
    n_cmp++;
    if (res !== 32'd2) begin n_fail++; $display("FAIL basic_rem_result: got %h expected %h", res, 32'd2); end
    run_op(OP_DIV, 32'd1000000, 32'd3, res, lat);
    n_cmp++;
    if (res !== 32'd333333) begin n_fail++; $display("FAIL large_div_result: got %h expected %h", res, 32'd333333); end
  endtask

  task automatic test_signed;
    logic [W-1:0] res;
    int lat;
    run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, res, lat);   // -7 rem 2 = -1
    n_cmp++;
    if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL neg_rem_result: got %h expected %h", res, 32'hFFFF_FFFF); end
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, res, lat);   // 7 div -2 = -3
    n_cmp++;
    if (res !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_negb_result: got %h expected %h", res, 32'hFFFF_FFFD); end
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, res, lat);   // -7 div 2 = -3
    n_cmp++;
    if (res !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_nega_result: got %h expected %h", res, 32'hFFFF_FFFD); end
    run_op(OP_REM, 32'd7, 32'hFFFF_FFFE, res, lat);   // 7 rem -2 = 1
    n_cmp++;
    if (res !== 32'd1) begin n_fail++; $display("FAIL rem_negb_result: got %h expected %h", res, 32'd1); end
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, res, lat);  // -7 div -2 = 3
    n_cmp++;
    if (res !== 32'd3) begin n_fail++; $display("FAIL div_negab_result: got %h expected %h", res, 32'd3); end
  endtask

  task automatic test_div_zero;
    logic [W-1:0] res;
    int lat;
    run_op(OP_DIV, 32'h1234_5678, 32'd0, res, lat);
    n_cmp++;
    if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divzero_div_result: got %h expected %h", res, 32'hFFFF_FFFF); end
    n_cmp++;
    if (lat !== SPECIAL_LAT) begin n_fail++; $display("FAIL divzero_div_latency: got %0d expected %0d", lat, SPECIAL_LAT); end
    run_op(OP_REM, 32'h1234_5678, 32'd0, res, lat);
    n_cmp++;
    if (res !== 32'h1234_5678) begin n_fail++; $display("FAIL divzero_rem_result: got %h expected %h", res, 32'h1234_5678); end
    n_cmp++;
    if (lat !== SPECIAL_LAT) begin n_fail++; $display("FAIL divzero_rem_latency: got %0d expected %0d", lat, SPECIAL_LAT); end
    run_op(OP_REM, 32'hFFFF_FFF0, 32'd0, res, lat);   // negative dividend returned unchanged
    n_cmp++;
    if (res !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL divzero_negrem_result: got %h expected %h", res, 32'hFFFF_FFF0); end
  endtask

  task automatic test_overflow;
    logic [W-1:0] res;
    int lat;
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
    n_cmp++;
    if (res !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_div_result: got %h expected %h", res, 32'h8000_0000); end
    n_cmp++;
    if (lat !== SPECIAL_LAT) begin n_fail++; $display("FAIL ovf_div_latency: got %0d expected %0d", lat, SPECIAL_LAT); end
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
    n_cmp++;
    if (res !== 32'd0) begin n_fail++; $display("FAIL ovf_rem_result: got %h expected 0", res); end
    // Most negative dividend by +1 is not a special case.
    run_op(OP_DIV, 32'h8000_0000, 32'd1, res, lat);
    n_cmp++;
    if (res !== 32'h8000_0000) begin n_fail++; $display("FAIL min_div_one_result: got %h expected %h", res, 32'h8000_0000); end
    n_cmp++;
    if (lat !== NORMAL_LAT) begin n_fail++; $display("FAIL min_div_one_latency: got %0d expected %0d", lat, NORMAL_LAT); end
  endtask

  task automatic test_protocol;
    logic [W-1:0] res;
    int lat;
    // Non-div/rem opcode must be ignored.
    @(negedge clk);
    alu_control = 4'b0000;
    a = 32'd50;
    b = 32'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL illegal_op_busy: got %b expected 0", busy); end
    @(posedge clk);
    #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL illegal_op_idle: busy=%b done=%b expected 0 0", busy, done); end
    $display("illegal opcode 0000 issued");

    // Start re-pulsed during CALC with new operands must be ignored.
    @(negedge clk);
    alu_control = OP_DIV;
    a = 32'd100;
    b = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL calc_busy: got %b expected 1", busy); end
    repeat (5) @(posedge clk);
    #1;
    a = 32'd50;
    b = 32'd5;
    alu_control = OP_REM;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, res);
    $display("restart during calc -> result=%h latency=%0d", res, lat);
    n_cmp++;
    if (res !== 32'd14) begin n_fail++; $display("FAIL restart_ignored_result: got %h expected %h", res, 32'd14); end
    n_cmp++;
    if (lat !== NORMAL_LAT - 6) begin n_fail++; $display("FAIL restart_ignored_latency: got %0d expected %0d", lat, NORMAL_LAT - 6); end

    // Result must hold while idle.
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (result !== 32'd14 || busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_hold_%0d: result=%h busy=%b done=%b expected %h 0 0", i, result, busy, done, 32'd14);
      end
      @(posedge clk);
      #1;
    end
    $display("result held over 5 idle cycles");
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] res;
    int lat;
    @(negedge clk);
    alu_control = OP_DIV;
    a = 32'd20;
    b = 32'd4;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, res);
    $display("first op 20/4 -> result=%h latency=%0d", res, lat);
    n_cmp++;
    if (res !== 32'd5) begin n_fail++; $display("FAIL b2b_first_result: got %h expected %h", res, 32'd5); end
    // start raised during the DONE cycle: ignored at the edge ending DONE.
    a = 32'd30;
    b = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_done_start_ignored: busy=%b expected 0", busy); end
    @(posedge clk);
    #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_next_accept: busy=%b expected 1", busy); end
    wait_done(lat, res);
    $display("second op 30/3 -> result=%h latency=%0d", res, lat);
    n_cmp++;
    if (res !== 32'd10) begin n_fail++; $display("FAIL b2b_second_result: got %h expected %h", res, 32'd10); end
    n_cmp++;
    if (lat !== NORMAL_LAT) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected %0d", lat, NORMAL_LAT); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_op;
    logic [W-1:0] res;
    int lat;
    @(negedge clk);
    alu_control = OP_DIV;
    a = 32'd1000;
    b = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    $display("reset asserted mid-operation");
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_cmp++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected 0", done); end
    n_cmp++;
    if (result !== '0) begin n_fail++; $display("FAIL midrst_result: got %h expected 0", result); end
    @(negedge clk);
    rst = 1'b0;
    run_op(OP_DIV, 32'd9, 32'd3, res, lat);
    n_cmp++;
    if (res !== 32'd3) begin n_fail++; $display("FAIL after_rst_result: got %h expected %h", res, 32'd3); end
    n_cmp++;
    if (lat !== NORMAL_LAT) begin n_fail++; $display("FAIL after_rst_latency: got %0d expected %0d", lat, NORMAL_LAT); end
  endtask

  initial begin
    test_reset();
    test_basic_div();
    test_signed();
    test_div_zero();
    test_overflow();
    test_protocol();
    test_back_to_back();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
